fp_add_seq_ctrl: RTL and testbench
==================================

Name: fp_add_seq_ctrl

Overview:
Sequential issue/response controller that sits directly upstream of the combinational single-precision adder and also consumes its outputs. It accepts add/sub requests over valid/ready, registers the operands and the resolved rounding mode onto the adder inputs, and waits a fixed settle latency. It then captures the result and the overflow/underflow outputs, derives the invalid flag, and returns the response over valid/ready. It also keeps a RISC-V-style sticky exception-flag register.

Parameters:
ADDER_LATENCY, 1, number of cycles the adder inputs are held before the result is sampled; legal range 1..15.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request ready
req_a  in  32  operand A (IEEE-754 single)
req_b  in  32  operand B
req_sub  in  1  1 = A-B (invert sign of B)
req_rm  in  3  rounding mode; 3'b111 = dynamic
frm  in  3  dynamic rounding mode from CSR
add_a  out  32  to adder fp_a
add_b  out  32  to adder fp_b
add_rm  out  3  to adder r_mode
add_result  in  32  from adder fp_result
add_overflow  in  1  from adder
add_underflow  in  1  from adder
resp_valid  out  1  response valid
resp_ready  in  1  response ready
resp_result  out  32  result
resp_flags  out  5  {NV,DZ,OF,UF,NX} for this operation
resp_illegal  out  1  illegal rounding mode
fflags  out  5  sticky accumulated flags
flags_clr  in  1  clear sticky flags
busy  out  1  state != IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state IDLE; all outputs 0 except req_ready=1. This covers resp_*, add_*, fflags and busy.
- Reset mid-operation: the transaction is dropped with no response, and fflags is cleared.
- FSM states: IDLE, EXEC, RESP.
- req_ready = (state==IDLE). A request fires on req_valid&&req_ready at a rising edge; this is cycle 0.
- Rounding-mode resolution: rm = (req_rm==3'b111) ? frm : req_rm.
- Illegal rounding mode: if the resolved rm is 3'b101, 3'b110 or 3'b111 (the last when frm itself is 111):
  - go IDLE->RESP;
  - resp_valid=1 in cycle 1;
  - resp_result=32'h7fc00000, resp_flags=0, resp_illegal=1;
  - add_* unchanged, fflags unchanged.
- Legal request:
  - latch add_a=req_a, add_b={req_b[31]^req_sub, req_b[30:0]}, add_rm=rm;
  - go IDLE->EXEC with counter loaded to ADDER_LATENCY-1;
  - add_* are held stable through EXEC and RESP.
- EXEC:
  - counter decrements each cycle;
  - at counter==0, capture the result and go to RESP;
  - resp_valid rises in cycle ADDER_LATENCY+1.
- Capture rules:
  - NV = inf+(-inf) on add_a/add_b (both exp 8'hFF, mant 0, signs differ), OR either operand is an sNaN (exp FF, mant!=0, mant[22]==0).
  - If NV, resp_result=32'h7fc00000; otherwise resp_result=add_result.
  - OF=add_overflow, UF=add_underflow, NX=OF|UF, DZ=0.
- Sticky flags:
  - fflags <= (flags_clr ? 0 : fflags) | new_flags, in the capture cycle only;
  - when flags_clr and a capture coincide, the new flags survive;
  - flags_clr alone clears fflags on the next edge.
- RESP:
  - resp_* held stable while resp_valid && !resp_ready;
  - on resp_ready, go to IDLE and drop resp_valid next cycle;
  - req_ready returns 1 in the cycle after the response handshake (no same-cycle reissue).

Optional Feature:
FP_ADD_ZERO_BYPASS_EN
- Defined: a legal request where exactly one operand (after the sub sign flip) is ±0 and the other is not NaN takes IDLE->RESP directly, skipping EXEC.
  - resp_valid is 1 in cycle 1; resp_result = the non-zero operand; resp_flags=0.
  - add_* are still latched.
- Undefined: no bypass; every legal request goes through EXEC.

Decomposition:
- Package fp_add_pkg contains:
  - rm_e enum: RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100, DYN=111;
  - flag bit indices: NV=4, DZ=3, OF=2, UF=1, NX=0;
  - QNAN constant 32'h7fc00000;
  - state_e enum {IDLE, EXEC, RESP}.
- Sub-module fp_add_classify (combinational): takes the two operands and returns is_zero, is_snan, is_qnan, is_inf per operand, plus inf_cancel. It is used by both the NV logic and the bypass logic.

Test Plan:
1. ADDER_LATENCY=1; a=3F800000, b=40000000, rm=000; adder model returns 40400000 -> resp_valid in cycle 2, result 40400000, flags 0, fflags 0.
2. rm=111 with frm=001 -> add_rm=001. Then rm=101 -> resp_valid in cycle 1, result 7fc00000, resp_illegal=1, fflags unchanged.
3. a=7f800000, b=7f800000, sub=1 -> add_b=ff800000, result 7fc00000, resp_flags=10000, fflags=10000.
4. Adder returns overflow=1 -> resp_flags=00101, fflags ORs to 10101. Then flags_clr pulse -> fflags=0. Clear coincident with an underflow capture -> fflags=00011.
5. resp_ready held 0 for 5 cycles -> resp_* stable, req_ready=0. resp_ready=1 -> resp_valid=0 and req_ready=1 next cycle.
6. rst pulsed in EXEC with ADDER_LATENCY=4 -> next cycle resp_valid=0, req_ready=1, fflags=0, and no response ever appears.

Source files
------------

// File: rtl/fp_add_pkg.sv
// Shared types, widths and operand classification for the single-precision add sequencer.
package fp_add_pkg;

    localparam int unsigned FP_W   = 32;
    localparam int unsigned RM_W   = 3;
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned CNT_W  = 4;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    localparam logic [FP_W-1:0] QNAN = 32'h7fc00000;

    typedef enum logic [RM_W-1:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } rm_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    typedef struct packed {
        logic is_zero;
        logic is_snan;
        logic is_qnan;
        logic is_inf;
    } fp_class_t;

    // IEEE-754 single-precision special-value decode; mant[22] separates quiet from signalling NaN.
    function automatic fp_class_t fp_classify(input logic [FP_W-1:0] x);
        fp_class_t c;
        logic      exp_max;
        logic      mant_zero;
        exp_max   = &x[30:23];
        mant_zero = ~|x[22:0];
        c.is_zero = ~|x[30:0];
        c.is_inf  = exp_max & mant_zero;
        c.is_qnan = exp_max & x[22];
        c.is_snan = exp_max & ~mant_zero & ~x[22];
        return c;
    endfunction

endpackage

// File: rtl/fp_add_classify.sv
// Classifies both adder operands and detects an inf + (-inf) cancellation.
module fp_add_classify
    import fp_add_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output fp_class_t       cls_a,
    output fp_class_t       cls_b,
    output logic            inf_cancel
);

    assign cls_a      = fp_classify(a);
    assign cls_b      = fp_classify(b);
    assign inf_cancel = cls_a.is_inf & cls_b.is_inf & (a[31] ^ b[31]);

endmodule

// File: rtl/fp_add_seq_ctrl.sv
// Issue/response sequencer around the combinational single-precision adder, with sticky fflags.
// Optional macro FP_ADD_ZERO_BYPASS_EN: x +/- 0 requests are answered directly without waiting on the adder.
module fp_add_seq_ctrl
    import fp_add_pkg::*;
#(
    parameter int unsigned ADDER_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [FP_W-1:0]   req_a,
    input  logic [FP_W-1:0]   req_b,
    input  logic              req_sub,
    input  logic [RM_W-1:0]   req_rm,
    input  logic [RM_W-1:0]   frm,
    output logic [FP_W-1:0]   add_a,
    output logic [FP_W-1:0]   add_b,
    output logic [RM_W-1:0]   add_rm,
    input  logic [FP_W-1:0]   add_result,
    input  logic              add_overflow,
    input  logic              add_underflow,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [FP_W-1:0]   resp_result,
    output logic [FLAG_W-1:0] resp_flags,
    output logic              resp_illegal,
    output logic [FLAG_W-1:0] fflags,
    input  logic              flags_clr,
    output logic              busy
);

    state_e              state;
    state_e              state_d;
    logic [CNT_W-1:0]    cnt;
    logic [RM_W-1:0]     rm_c;
    logic                rm_illegal_c;
    logic [FP_W-1:0]     b_eff_c;
    logic                bypass_c;
    logic [FP_W-1:0]     byp_result_c;
    fp_class_t           cls_a;
    fp_class_t           cls_b;
    logic                inf_cancel;
    logic                nv_c;
    logic [FLAG_W-1:0]   new_flags_c;
    logic                issue_exe;
    logic                issue_byp;
    logic                issue_ill;
    logic                capture;

    assign rm_c         = (req_rm == DYN) ? frm : req_rm;
    assign rm_illegal_c = rm_c[2] & (rm_c[1] | rm_c[0]);
    assign b_eff_c      = {req_b[31] ^ req_sub, req_b[30:0]};

    // Invalid detection runs on the held adder inputs, in step with the sampled result.
    fp_add_classify u_cls (
        .a          (add_a),
        .b          (add_b),
        .cls_a      (cls_a),
        .cls_b      (cls_b),
        .inf_cancel (inf_cancel)
    );

    logic unused_cls;
    assign unused_cls = &{cls_a.is_zero, cls_a.is_qnan, cls_a.is_inf,
                          cls_b.is_zero, cls_b.is_qnan, cls_b.is_inf};

    assign nv_c = inf_cancel | cls_a.is_snan | cls_b.is_snan;

    always_comb begin
        new_flags_c          = '0;
        new_flags_c[FLAG_NV] = nv_c;
        new_flags_c[FLAG_OF] = add_overflow;
        new_flags_c[FLAG_UF] = add_underflow;
        new_flags_c[FLAG_NX] = add_overflow | add_underflow;
    end

`ifdef FP_ADD_ZERO_BYPASS_EN
    fp_class_t req_cls_a;
    fp_class_t req_cls_b;
    logic      req_inf_cancel;

    fp_add_classify u_req_cls (
        .a          (req_a),
        .b          (b_eff_c),
        .cls_a      (req_cls_a),
        .cls_b      (req_cls_b),
        .inf_cancel (req_inf_cancel)
    );

    logic unused_req_cls;
    assign unused_req_cls = &{req_cls_a.is_inf, req_cls_b.is_inf, req_inf_cancel};

    assign bypass_c = (req_cls_a.is_zero ^ req_cls_b.is_zero)
                    & ~(req_cls_a.is_snan | req_cls_a.is_qnan | req_cls_b.is_snan | req_cls_b.is_qnan);
    assign byp_result_c = req_cls_a.is_zero ? b_eff_c : req_a;
`else
    assign bypass_c     = 1'b0;
    assign byp_result_c = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        issue_exe = 1'b0;
        issue_byp = 1'b0;
        issue_ill = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (rm_illegal_c) begin
                        issue_ill = 1'b1;
                        state_d   = RESP;
                    end else if (bypass_c) begin
                        issue_byp = 1'b1;
                        state_d   = RESP;
                    end else begin
                        issue_exe = 1'b1;
                        state_d   = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs track the next state so they are valid straight out of the flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            resp_valid   <= 1'b0;
            add_a        <= '0;
            add_b        <= '0;
            add_rm       <= '0;
            cnt          <= '0;
            resp_result  <= '0;
            resp_flags   <= '0;
            resp_illegal <= 1'b0;
            fflags       <= '0;
        end else begin
            req_ready  <= (state_d == IDLE);
            busy       <= (state_d != IDLE);
            resp_valid <= (state_d == RESP);

            if (issue_exe | issue_byp) begin
                add_a  <= req_a;
                add_b  <= b_eff_c;
                add_rm <= rm_c;
            end

            if (issue_exe)                        cnt <= CNT_W'(ADDER_LATENCY - 1);
            else if (state == EXEC && cnt != '0)  cnt <= cnt - CNT_W'(1);

            if (issue_ill) begin
                resp_result  <= QNAN;
                resp_flags   <= '0;
                resp_illegal <= 1'b1;
            end else if (issue_byp) begin
                resp_result  <= byp_result_c;
                resp_flags   <= '0;
                resp_illegal <= 1'b0;
            end else if (capture) begin
                resp_result  <= nv_c ? QNAN : add_result;
                resp_flags   <= new_flags_c;
                resp_illegal <= 1'b0;
            end

            // A clear coinciding with a capture still keeps that operation's flags.
            fflags <= (flags_clr ? '0 : fflags) | (capture ? new_flags_c : '0);
        end
    end

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Scoreboard bench for fp_add_seq_ctrl: a transaction-level model predicts responses, handshakes and sticky flags.
`timescale 1ns/1ps
module tb_fp_add_seq_ctrl;

    localparam int unsigned LAT    = 4;
    localparam logic [31:0] QNAN_C = 32'h7fc00000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_sub;
    logic [2:0]  req_rm;
    logic [2:0]  frm;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [2:0]  add_rm;
    logic [31:0] add_result;
    logic        add_overflow;
    logic        add_underflow;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic [4:0]  resp_flags;
    logic        resp_illegal;
    logic [4:0]  fflags;
    logic        flags_clr = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    fp_add_seq_ctrl #(.ADDER_LATENCY(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_sub       (req_sub),
        .req_rm        (req_rm),
        .frm           (frm),
        .add_a         (add_a),
        .add_b         (add_b),
        .add_rm        (add_rm),
        .add_result    (add_result),
        .add_overflow  (add_overflow),
        .add_underflow (add_underflow),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
        .resp_flags    (resp_flags),
        .resp_illegal  (resp_illegal),
        .fflags        (fflags),
        .flags_clr     (flags_clr),
        .busy          (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endtask

    // ---------------- adder stand-in: only correct once its inputs have been stable long enough
    logic force_of = 1'b0;
    logic force_uf = 1'b0;
    logic rand_flags = 1'b0;

    function automatic logic [33:0] adder_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        logic [31:0] h;
        if (a == 32'h3f800000 && b == 32'h40000000) h = 32'h40400000;
        else h = (a * 32'h9e3779b1) ^ {b[15:0], b[31:16]} ^ {29'd0, rm};
        return {force_of | (rand_flags && h[3:0] == 4'h3), force_uf | (rand_flags && h[3:0] == 4'h5), h};
    endfunction

    int unsigned age = 0;
    logic [66:0] last_in = '0;
    always @(negedge clk) begin
        logic [33:0] r;
        if ({add_rm, add_a, add_b} !== last_in) begin
            age     = 0;
            last_in = {add_rm, add_a, add_b};
        end else if (age < 100) begin
            age++;
        end
        r = adder_fn(add_a, add_b, add_rm);
        if (age + 1 >= LAT) {add_overflow, add_underflow, add_result} = r;
        else                {add_overflow, add_underflow, add_result} = ~r;
    end

    // ---------------- reference model
    typedef struct {
        logic [31:0] result;
        logic [4:0]  flags;
        logic        illegal;
    } exp_t;

    exp_t        sb_q[$];
    logic        m_busy = 1'b0;
    logic        m_rv = 1'b0;
    int          m_wait = 0;
    logic [4:0]  ff_m = '0;
    logic [4:0]  pend_nf = '0;
    logic [31:0] m_add_a = '0;
    logic [31:0] m_add_b = '0;
    logic [2:0]  m_add_rm = '0;

    function automatic logic f_zero(input logic [31:0] x); return x[30:0] == 31'd0; endfunction
    function automatic logic f_inf(input logic [31:0] x);  return x[30:23] == 8'hFF && x[22:0] == 23'd0; endfunction
    function automatic logic f_nan(input logic [31:0] x);  return x[30:23] == 8'hFF && x[22:0] != 23'd0; endfunction
    function automatic logic f_snan(input logic [31:0] x); return f_nan(x) && !x[22]; endfunction

    task automatic model_issue();
        logic [2:0]  rm;
        logic [31:0] b;
        logic [33:0] r;
        logic        nv;
        exp_t        e;
        rm     = (req_rm == 3'b111) ? frm : req_rm;
        b      = {req_b[31] ^ req_sub, req_b[30:0]};
        m_busy = 1'b1;
        if (rm == 3'b101 || rm == 3'b110 || rm == 3'b111) begin
            e.result = QNAN_C; e.flags = '0; e.illegal = 1'b1;
            m_rv = 1'b1;
        end else begin
            m_add_a = req_a; m_add_b = b; m_add_rm = rm;
            e.illegal = 1'b0;
`ifdef FP_ADD_ZERO_BYPASS_EN
            if ((f_zero(req_a) != f_zero(b)) && !f_nan(req_a) && !f_nan(b)) begin
                e.result = f_zero(req_a) ? b : req_a;
                e.flags  = '0;
                m_rv     = 1'b1;
                sb_q.push_back(e);
                return;
            end
`endif
            r  = adder_fn(req_a, b, rm);
            nv = (f_inf(req_a) && f_inf(b) && req_a[31] != b[31]) || f_snan(req_a) || f_snan(b);
            e.result = nv ? QNAN_C : r[31:0];
            e.flags  = {nv, 1'b0, r[33], r[32], r[33] | r[32]};
            pend_nf  = e.flags;
            m_wait   = LAT;
        end
        sb_q.push_back(e);
    endtask

    always @(posedge clk) begin
        logic cap;
        cap = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_rv = 1'b0; m_wait = 0; ff_m = '0; pend_nf = '0;
            m_add_a = '0; m_add_b = '0; m_add_rm = '0;
            sb_q.delete();
        end else begin
            if (!m_busy) begin
                if (req_valid) model_issue();
            end else if (m_rv) begin
                if (resp_ready) begin m_rv = 1'b0; m_busy = 1'b0; end
            end else begin
                m_wait--;
                if (m_wait == 0) begin cap = 1'b1; m_rv = 1'b1; end
            end
            ff_m = (flags_clr ? 5'd0 : ff_m) | (cap ? pend_nf : 5'd0);
        end
    end

    // ---------------- monitor
    logic mon_en = 1'b0;
    exp_t cur;
    logic cur_v = 1'b0;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("req_ready",  32'(req_ready),  32'(!m_busy));
            chk("resp_valid", 32'(resp_valid), 32'(m_rv));
            chk("busy",       32'(busy),       32'(m_busy));
            chk("fflags",     32'(fflags),     32'(ff_m));
            chk("add_a",      add_a,           m_add_a);
            chk("add_b",      add_b,           m_add_b);
            chk("add_rm",     32'(add_rm),     32'(m_add_rm));
            if (resp_valid) begin
                if (!cur_v) begin
                    if (sb_q.size() == 0) begin
                        fail_now("resp_unexpected");
                    end else begin
                        cur   = sb_q.pop_front();
                        cur_v = 1'b1;
                    end
                end
                if (cur_v) begin
                    chk("resp_result",  resp_result,       cur.result);
                    chk("resp_flags",   32'(resp_flags),   32'(cur.flags));
                    chk("resp_illegal", 32'(resp_illegal), 32'(cur.illegal));
                end
            end else begin
                cur_v = 1'b0;
            end
        end else begin
            cur_v = 1'b0;
        end
    end

    // ---------------- background drivers for resp_ready and flags_clr
    int unsigned rr_pct = 100;
    logic        rr_hold = 1'b0;
    int unsigned clr_pct = 0;
    logic        clr_req = 1'b0;
    always @(posedge clk) begin
        #2;
        resp_ready = !rr_hold && ($urandom_range(0, 99) < rr_pct);
        flags_clr  = clr_req || ($urandom_range(0, 99) < clr_pct);
    end

    // ---------------- stimulus
    task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic [2:0] rm);
        logic rdy;
        int   n;
        req_a = a; req_b = b; req_sub = sub; req_rm = rm; req_valid = 1'b1;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 200) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) fail_now("req_handshake");
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_busy && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (m_busy) fail_now("wait_idle");
    endtask

    function automatic logic [31:0] pick_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0:       return {r[31], 31'd0};
            1:       return {r[31], 8'hFF, 23'd0};
            2:       return {r[31], 8'hFF, 1'b1, r[21:0]};
            3:       return {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
            default: return r;
        endcase
    endfunction

    initial begin
        #500us;
        fail_now("watchdog");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_sub = 1'b0; req_rm = '0; frm = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready",   32'(req_ready),    32'd1);
        chk("rst_resp_valid",  32'(resp_valid),   32'd0);
        chk("rst_busy",        32'(busy),         32'd0);
        chk("rst_fflags",      32'(fflags),       32'd0);
        chk("rst_add_a",       add_a,             32'd0);
        chk("rst_resp_result", resp_result,       32'd0);
        chk("rst_resp_ill",    32'(resp_illegal), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // basic add
        do_req(32'h3f800000, 32'h40000000, 1'b0, 3'b000);
        wait_idle();
        chk("t1_fflags", 32'(fflags), 32'd0);

        // dynamic and illegal rounding modes
        frm = 3'b001;
        do_req(32'h3fc00000, 32'h40800000, 1'b0, 3'b111);
        wait_idle();
        chk("t2_add_rm", 32'(add_rm), 32'd1);
        do_req(32'h12345678, 32'h01020304, 1'b0, 3'b101);
        wait_idle();
        chk("t2_ill_add_rm", 32'(add_rm), 32'd1);
        frm = 3'b111;
        do_req(32'h12345678, 32'h01020304, 1'b1, 3'b111);
        wait_idle();
        frm = 3'b000;
        do_req(32'h0badf00d, 32'h00c0ffee, 1'b0, 3'b110);
        wait_idle();
        chk("t2_fflags", 32'(fflags), 32'd0);

        // inf - inf is invalid
        do_req(32'h7f800000, 32'h7f800000, 1'b1, 3'b000);
        wait_idle();
        chk("t3_add_b",  add_b,       32'hff800000);
        chk("t3_result", resp_result, QNAN_C);
        chk("t3_fflags", 32'(fflags), 32'h10);

        // overflow accumulation, clear, and clear coinciding with a capture
        force_of = 1'b1;
        do_req(32'h3f800000, 32'h3f800000, 1'b0, 3'b000);
        wait_idle();
        chk("t4_flags",  32'(resp_flags), 32'h05);
        chk("t4_fflags", 32'(fflags),     32'h15);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        @(posedge clk); #1;
        chk("t4_clr", 32'(fflags), 32'd0);
        do_req(32'h3f800001, 32'h3f800000, 1'b0, 3'b001);
        wait_idle();
        chk("t4_of_again", 32'(fflags), 32'h05);
        force_of = 1'b0;
        force_uf = 1'b1;
        do_req(32'h00000011, 32'h00000022, 1'b0, 3'b000);
        repeat (LAT - 1) @(posedge clk);
        #1;
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        wait_idle();
        chk("t4_coinc", 32'(fflags), 32'h03);
        force_uf = 1'b0;

        // response back-pressure
        rr_hold = 1'b1;
        do_req(32'h40490fdb, 32'hc0490fdb, 1'b0, 3'b010);
        repeat (LAT + 6) @(posedge clk);
        #1;
        chk("t5_stall_valid", 32'(resp_valid), 32'd1);
        chk("t5_stall_ready", 32'(req_ready),  32'd0);
        rr_hold = 1'b0;
        wait_idle();

        // reset while the adder is being waited on
        do_req(32'h41200000, 32'h41a00000, 1'b0, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_resp_valid", 32'(resp_valid), 32'd0);
        chk("t6_req_ready",  32'(req_ready),  32'd1);
        chk("t6_fflags",     32'(fflags),     32'd0);
        repeat (LAT + 8) @(posedge clk);
        #1;
        chk("t6_no_resp", 32'(resp_valid), 32'd0);

        // randomized traffic
        rand_flags = 1'b1;
        rr_pct     = 70;
        clr_pct    = 5;
        for (int i = 0; i < 200; i++) begin
            frm = 3'($urandom_range(0, 7));
            do_req(pick_op(), pick_op(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end
        rr_pct  = 100;
        clr_pct = 0;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
